rv_mem_arbiter: RTL

- Shares the core's single external memory port between instruction fetch and the data-memory stage.
- The data-memory stage supplies load/store address, write data, byte lanes and direction.
- Grants one requester at a time and drives a registered single-outstanding bus transaction.
- Routes ack/rdata back to the granted requester and recovers from a silent bus with a timeout error.

---
 rtl/rv_mem_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rv_mem_arbiter.sv
// Two-master arbiter sharing one external memory port between instruction fetch and the data stage.
// Runs one registered bus transaction at a time and forces an error completion on a silent bus.
module rv_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_ibus_req,
    input  logic [29:0] i_ibus_addr,
    output logic        o_ibus_ack,
    output logic        o_ibus_err,

    input  logic        i_dbus_req,
    input  logic        i_dbus_we,
    input  logic [31:0] i_dbus_addr,
    input  logic [3:0]  i_dbus_sel,
    input  logic [31:0] i_dbus_wdata,
    output logic        o_dbus_ack,
    output logic        o_dbus_err,

    output logic [31:0] o_rdata,

    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [29:0] o_bus_addr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IBUS,
        S_DBUS
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t          state;
    state_t          last;
    logic [TO_W-1:0] to_cnt;

    logic busy;
    logic timeout_hit;
    logic done;
    logic grant_dbus;

    // Byte offset is meaningless on a word-addressed bus.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^i_dbus_addr[1:0];

    assign busy        = (state != S_IDLE);
    assign timeout_hit = (TIMEOUT != 0) && busy && (to_cnt == TO_LIMIT);
    assign done        = busy && (i_bus_ack || timeout_hit);

    // With both requesters pending, the one that did not win last time goes next.
    assign grant_dbus  = i_dbus_req && (!i_ibus_req || (last == S_IBUS));

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        o_ibus_ack = 1'b0;
        o_ibus_err = 1'b0;
        o_dbus_ack = 1'b0;
        o_dbus_err = 1'b0;
        o_rdata    = '0;
        if (state == S_IBUS) begin
            o_ibus_ack = done;
            o_ibus_err = timeout_hit && !i_bus_ack;
        end
        if (state == S_DBUS) begin
            o_dbus_ack = done;
            o_dbus_err = timeout_hit && !i_bus_ack;
        end
        if (busy && i_bus_ack) begin
            o_rdata = i_bus_rdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            last        <= S_IBUS;
            to_cnt      <= '0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_sel   <= '0;
            o_bus_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (i_ibus_req || i_dbus_req) begin
                        o_bus_req <= 1'b1;
                        if (grant_dbus) begin
                            state       <= S_DBUS;
                            last        <= S_DBUS;
                            o_bus_we    <= i_dbus_we;
                            o_bus_addr  <= i_dbus_addr[31:2];
                            o_bus_sel   <= i_dbus_sel;
                            o_bus_wdata <= i_dbus_wdata;
                        end else begin
                            // Fetches leave the write-data register untouched.
                            state      <= S_IBUS;
                            last       <= S_IBUS;
                            o_bus_we   <= 1'b0;
                            o_bus_addr <= i_ibus_addr;
                            o_bus_sel  <= 4'b1111;
                        end
                    end
                end
                default: begin
                    if (done) begin
                        state     <= S_IDLE;
                        o_bus_req <= 1'b0;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
